// File: rtl/irq_frontend_pkg.sv
// rtl/irq_frontend_pkg.sv - shared width, FSM states and grant-select functions for irq_request_frontend
// ROUND_ROBIN_EN adds the pointer-rotated select and onehot-to-index helpers.
package irq_frontend_pkg;

  localparam int REQ_W = 8;

  typedef enum logic {ST_IDLE, ST_OFFER} state_e;

  // Highest set bit wins: bit 7 first, bit 0 last.
  function automatic logic [REQ_W-1:0] select_fixed(input logic [REQ_W-1:0] elig);
    logic [REQ_W-1:0] g;
    g = '0;
    for (int i = REQ_W - 1; i >= 0; i--) begin
      if (elig[i] && (g == '0)) g[i] = 1'b1;
    end
    return g;
  endfunction

`ifdef ROUND_ROBIN_EN
  // Search starts at ptr-1 and wraps downward, so ptr itself is tried last.
  function automatic logic [REQ_W-1:0] select_rr(input logic [REQ_W-1:0] elig,
                                                 input logic [2:0] ptr);
    logic [REQ_W-1:0] g;
    logic [2:0]       idx;
    g = '0;
    for (int i = 1; i <= REQ_W; i++) begin
      idx = ptr - 3'(i);
      if (elig[idx] && (g == '0)) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [REQ_W-1:0] oh);
    logic [2:0] k;
    k = '0;
    for (int i = 0; i < REQ_W; i++) begin
      if (oh[i]) k = 3'(i);
    end
    return k;
  endfunction
`endif

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - single-bit SYNC_STAGES flop synchronizer, async active-low reset to 0
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[SYNC_STAGES-2:0], d};
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/irq_request_frontend.sv
// rtl/irq_request_frontend.sv - synchronize, latch and offer one-hot interrupt grants on valid/ready
// Optional macro ROUND_ROBIN_EN selects rotating priority instead of fixed bit-7-first priority.
module irq_request_frontend
  import irq_frontend_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_W-1:0] req_i,
  input  logic [REQ_W-1:0] mask_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [REQ_W-1:0] onehot_o,
  output logic [REQ_W-1:0] pending_o,
  output logic             lost_o
);

  logic [REQ_W-1:0] req_s;
  logic [REQ_W-1:0] req_d;
  logic [REQ_W-1:0] pending;
  logic [REQ_W-1:0] onehot_q, onehot_n;
  logic [REQ_W-1:0] set, clr, eligible;
  logic             lost_q;
  state_e           state_q, state_n;

  for (genvar b = 0; b < REQ_W; b++) begin : g_sync
    sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_i[b]),
      .q     (req_s[b])
    );
  end

  assign set      = (EDGE_MODE != 0) ? (req_s & ~req_d) : req_s;
  assign clr      = (state_q == ST_OFFER && ready_i) ? onehot_q : '0;
  assign eligible = pending & ~mask_i;

`ifdef ROUND_ROBIN_EN
  logic [2:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           ptr_q <= 3'd7;
    else if (clr != '0)   ptr_q <= onehot_idx(onehot_q);
  end
`endif

  always_comb begin
    state_n  = state_q;
    onehot_n = onehot_q;
    case (state_q)
      ST_IDLE: begin
        onehot_n = '0;
        if (eligible != '0) begin
`ifdef ROUND_ROBIN_EN
          onehot_n = select_rr(eligible, ptr_q);
`else
          onehot_n = select_fixed(eligible);
`endif
          state_n  = ST_OFFER;
        end
      end
      ST_OFFER: begin
        // Grant stays frozen until accepted, regardless of later mask or pending changes.
        if (ready_i) begin
          onehot_n = '0;
          state_n  = ST_IDLE;
        end
      end
      default: begin
        onehot_n = '0;
        state_n  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d    <= '0;
      pending  <= '0;
      lost_q   <= 1'b0;
      state_q  <= ST_IDLE;
      onehot_q <= '0;
    end else begin
      req_d    <= req_s;
      // A set landing on the bit being cleared keeps the new event.
      pending  <= (pending & ~clr) | set;
      if ((set & pending & ~clr) != '0) lost_q <= 1'b1;
      state_q  <= state_n;
      onehot_q <= onehot_n;
    end
  end

  assign valid_o   = (state_q == ST_OFFER);
  assign onehot_o  = onehot_q;
  assign pending_o = pending;
  assign lost_o    = lost_q;

endmodule

// File: doc/irq_request_frontend.md
# irq_request_frontend

Sequential front end that sits directly upstream of the 8-to-3 encoder. Captures eight asynchronous request lines, synchronizes them and holds each event in a pending register. Presents exactly one pending request at a time as a registered one-hot vector on a valid/ready handshake; the encoder consumes that vector and produces the 3-bit code. Each pending bit clears only when its grant is accepted.

## Interface
- SYNC_STAGES, 2, synchronizer depth per request line (legal 2..4)
- EDGE_MODE, 1, 1 = rising edge sets pending, 0 = high level sets pending
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_i  input  8  raw asynchronous request lines
- mask_i  input  8  1 = bit may not be granted; still latches pending; synchronous to clk
- ready_i  input  1  consumer accepts onehot_o this cycle
- valid_o  output  1  onehot_o holds a grant
- onehot_o  output  8  registered one-hot grant; all zero when valid_o = 0
- pending_o  output  8  current pending register
- lost_o  output  1  sticky; a set event hit an already-pending bit

## Operation
- Sync: per-bit SYNC_STAGES flop chain → req_s; extra flop req_d for edge detect.
- Set term: set = EDGE_MODE ? (req_s & ~req_d) : req_s.
- Pending update: pending <= (pending & ~clr) | set; set wins if set and clr hit the same bit in the same cycle (new event retained).
- lost_o: set when (set & pending & ~clr) != 0; cleared only by reset.
- Eligible vector: pending & ~mask_i.
- FSM, two states:
  - IDLE: valid_o = 0, onehot_o = 0. If eligible != 0: register the highest-priority eligible bit into onehot_o, valid_o <= 1 → OFFER.
  - OFFER: onehot_o and valid_o are held stable, with no change even if mask_i or pending change. On valid_o && ready_i: clr = onehot_o, valid_o <= 0, onehot_o <= 0 → IDLE.
- Exactly one IDLE cycle between consecutive grants.
- A mask applied after a grant is issued does not revoke that grant.
- Fixed priority: bit 7 highest, bit 0 lowest.
- Reset mid-operation: pending, sync chain, FSM, outputs and lost_o clear immediately. An outstanding grant is dropped without handshake.

## Timing
- Reset values: valid_o = 0, onehot_o = 8'h00, pending_o = 8'h00, lost_o = 0, state IDLE, round-robin pointer = 7.
- Latency with SYNC_STAGES = 2, for req_i first sampled high at edge E0:
  - req_s high after E1.
  - pending bit set at E2.
  - valid_o high after E3.
- General latency: pending at E(SYNC_STAGES), valid_o at E(SYNC_STAGES+1).
- Handshake: the transfer completes on the edge where valid_o && ready_i. The pending bit is cleared at that same edge. valid_o is low in the following cycle.
- ready_i while valid_o = 0 is ignored.

## Configuration
- Macro ROUND_ROBIN_EN.
  - Defined: a 3-bit pointer holds the last granted index k. The search order starts at k-1 and wraps downward through 0 to 7, so bit k is lowest priority next. The pointer updates on each accepted handshake and resets to 7, giving bit 6 first priority after reset.
  - Undefined: fixed priority, bit 7 highest. No pointer register is built.

## Structure
- Shared package irq_frontend_pkg holds:
  - REQ_W = 8
  - the state enum (ST_IDLE, ST_OFFER)
  - the priority-select function (fixed, and rotate-by-pointer when ROUND_ROBIN_EN is defined)
- One sub-module, sync_chain: parameterized SYNC_STAGES flop chain, 1 bit wide and instantiated per bit, asynchronous active-low reset to 0.
- The encoder is instantiated by the parent. It is not instantiated inside this block.

## Test plan
- Reset: hold rst_n = 0 with req_i = 8'hFF → all outputs 0. Release with req_i = 8'h00 → outputs stay 0.
- Single edge: req_i 8'h00→8'h08 at E0, ready_i = 1 →
  - pending_o = 8'h08 at E2
  - valid_o = 1 with onehot_o = 8'h08 after E3
  - pending_o = 8'h00 and valid_o = 0 after E4
- Fixed priority: req_i → 8'h12 at the same edge, ready_i = 1 → grants 8'h10, then idle gap, then 8'h02; lost_o stays 0.
- Backpressure and mask: req_i = 8'h81, ready_i = 0, mask_i changed to 8'h80 after the grant → onehot_o holds 8'h80. Then ready_i = 1 → next grant is 8'h01, with bit 7 not regranted.
- Collision: a second rising edge on bit 2 while it is pending and ungranted → lost_o = 1 and sticky. With EDGE_MODE = 0 and req_i[2] held high, the bit re-pends the cycle after clear.
- Round robin (ROUND_ROBIN_EN defined): req_i held 8'hFF with EDGE_MODE = 0 → grant sequence 8'h40, 8'h20, …, 8'h01, 8'h80, 8'h40.
